// File: rtl/regfile_dump_if.sv
// ---------------------------------------------------------------------------
// regfile_dump_if
//   Word stream from the register-file dump engine to the debug/trace sink.
//
//   Handshake: a word moves on every rising clock edge where out_valid and
//   out_ready are both high. Once out_valid is high, out_valid, out_data,
//   out_addr and out_last hold steady until that handshake happens. The
//   sink may drive out_ready freely, and out_ready may depend on out_valid.
//
//   Signals:
//     out_valid  master->slave  out_data/out_addr/out_last are valid
//     out_ready  slave->master  sink accepts the word this cycle
//     out_data   master->slave  captured register value (or checksum)
//     out_addr   master->slave  register address of out_data
//     out_last   master->slave  final word of the dump
// ---------------------------------------------------------------------------
interface regfile_dump_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_addr,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_addr,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/regfile_dump.sv
// ---------------------------------------------------------------------------
// regfile_dump
//   Debug read-out engine for the register file. A start pulse walks
//   addresses 0..NUM_REGS-1 through a dedicated read port, captures each
//   word and streams it out over regfile_dump_if (valid/ready).
//
//   Optional feature, macro REGFILE_DUMP_CHECKSUM_EN: an XOR accumulator of
//   all captured words is sent as one extra word (out_addr=0, out_last=1)
//   after the last register. Without the macro the stream is exactly
//   NUM_REGS words and out_last marks register NUM_REGS-1.
//
//   Ports:
//     clk        in   clock, rising edge
//     rst        in   asynchronous, active-low reset
//     start      in   single-cycle dump request, ignored unless idle
//     busy       out  dump in progress (registered)
//     done       out  one-cycle pulse after the final word handshakes
//     rd_addr    out  registered register-file read address
//     rd_data    in   combinational register-file read data for rd_addr
//     out_if     if   word stream (master side)
//     dbg_state  out  current FSM state encoding
//
//   Walk per word: READ (rd_addr stable, capture at the edge) then SEND
//   (hold until handshake). With out_ready high each word costs 2 cycles.
// ---------------------------------------------------------------------------
module regfile_dump #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [DATA_W-1:0]  rd_data,
  regfile_dump_if.master     out_if,
  output logic [2:0]         dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_SEND = 3'd2,
`ifdef REGFILE_DUMP_CHECKSUM_EN
    S_CSUM = 3'd3,
`endif
    S_DONE = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] acc_q, acc_d;
`endif

  logic handshake;
  assign handshake = valid_q && out_if.out_ready;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rd_addr_d = rd_addr_q;
    valid_d   = valid_q;
    data_d    = data_q;
    addr_d    = addr_q;
    last_d    = last_q;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    acc_d     = acc_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d     = '0;
          rd_addr_d = '0;
          state_d   = S_READ;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          acc_d     = '0;
`endif
        end
      end

      S_READ: begin
        data_d  = rd_data;
        addr_d  = idx_q;
        valid_d = 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
        // The checksum word carries out_last, so no register does.
        last_d  = 1'b0;
        acc_d   = acc_q ^ rd_data;
`else
        last_d  = (idx_q == LAST_IDX);
`endif
        state_d = S_SEND;
      end

      S_SEND: begin
        if (handshake) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (idx_q != LAST_IDX) begin
            idx_d     = idx_q + ADDR_W'(1);
            rd_addr_d = idx_q + ADDR_W'(1);
            state_d   = S_READ;
          end else begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
            // Load the checksum word on entry so CSUM presents it at once.
            // acc_q already includes the final register (folded in at READ).
            valid_d = 1'b1;
            data_d  = acc_q;
            addr_d  = '0;
            last_d  = 1'b1;
            state_d = S_CSUM;
`else
            state_d = S_DONE;
`endif
          end
        end
      end

`ifdef REGFILE_DUMP_CHECKSUM_EN
      S_CSUM: begin
        if (handshake) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          state_d = S_DONE;
        end
      end
`endif

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status flags follow the next state so they are registered with it.
    busy_d = (state_d == S_READ) || (state_d == S_SEND)
`ifdef REGFILE_DUMP_CHECKSUM_EN
             || (state_d == S_CSUM)
`endif
             ;
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      rd_addr_q <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      addr_q    <= '0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      acc_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rd_addr_q <= rd_addr_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      addr_q    <= addr_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      acc_q     <= acc_d;
`endif
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign rd_addr          = rd_addr_q;
  assign out_if.out_valid = valid_q;
  assign out_if.out_data  = data_q;
  assign out_if.out_addr  = addr_q;
  assign out_if.out_last  = last_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_regfile_dump.sv
// ---------------------------------------------------------------------------
// tb_regfile_dump
//   Directed bench for regfile_dump. A behavioural register file feeds
//   rd_data combinationally; writes land on the falling edge. Inputs change
//   and outputs are sampled on the falling edge, away from the active edge.
// ---------------------------------------------------------------------------
module tb_regfile_dump;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  localparam int NWORDS   = NUM_REGS + 1;
  localparam int DONE_CYC = 2 * NUM_REGS + 2;
`else
  localparam int NWORDS   = NUM_REGS;
  localparam int DONE_CYC = 2 * NUM_REGS + 1;
`endif

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_READ = 3'd1;
  localparam logic [2:0] S_SEND = 3'd2;
  localparam logic [2:0] S_DONE = 3'd4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [2:0]        dbg_state;

  logic [DATA_W-1:0] regs [NUM_REGS];
  assign rd_data = regs[rd_addr];

  regfile_dump_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dump_if ();

  regfile_dump #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_if    (dump_if),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [DATA_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic preload();
    for (int i = 0; i < NUM_REGS; i++) regs[i] = 32'h1000_0000 + 32'(i);
  endtask

  // Expected word stream: the preload pattern, optionally one register
  // replaced, then (checksum build) the XOR of everything before it.
  task automatic build_exp(input int over_idx, input logic [DATA_W-1:0] over_val);
    logic [DATA_W-1:0] x;
    exp_q.delete();
    x = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i == over_idx) exp_q.push_back(over_val);
      else               exp_q.push_back(32'h1000_0000 + 32'(i));
      x = x ^ exp_q[i];
    end
`ifdef REGFILE_DUMP_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},    busy, 0);
    check({tag, "_done"},    done, 0);
    check({tag, "_valid"},   dump_if.out_valid, 0);
    check({tag, "_data"},    dump_if.out_data, 0);
    check({tag, "_addr"},    dump_if.out_addr, 0);
    check({tag, "_last"},    dump_if.out_last, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_state"},   dbg_state, S_IDLE);
  endtask

  // Runs one full dump. bp_word/bp_len: hold out_ready low on that word;
  // start_word: pulse start while that word is presented; wr_read_at: write
  // R5=DEADBEEF during the READ of that address; wr_send_at: same write
  // during the SEND of that address. -1 disables each option.
  task automatic run_dump(input int bp_word, input int bp_len, input int start_word,
                          input int wr_read_at, input int wr_send_at, input bit chk_timing);
    int cyc;
    int w;
    bit wrote;
    logic [DATA_W-1:0] exp_d;
    logic [ADDR_W-1:0] exp_a;

    dump_if.out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    check("start_busy",  busy, 1);
    check("start_state", dbg_state, S_READ);
    check("start_valid", dump_if.out_valid, 0);

    w = 0;
    wrote = 1'b0;
    while (w < NWORDS && cyc < 300) begin
      if (!wrote && wr_read_at >= 0 && dbg_state == S_READ && rd_addr == ADDR_W'(wr_read_at)) begin
        regs[5] = 32'hDEAD_BEEF;
        wrote = 1'b1;
      end
      if (!wrote && wr_send_at >= 0 && dbg_state == S_SEND && dump_if.out_valid &&
          dump_if.out_addr == ADDR_W'(wr_send_at)) begin
        regs[5] = 32'hDEAD_BEEF;
        wrote = 1'b1;
      end
      if (done) check("early_done", done, 0);

      if (dump_if.out_valid) begin
        exp_d = exp_q.pop_front();
        exp_a = (w >= NUM_REGS) ? '0 : ADDR_W'(w);
        check("word_addr", dump_if.out_addr, exp_a);
        check("word_data", dump_if.out_data, exp_d);
        check("word_last", dump_if.out_last, (w == NWORDS - 1) ? 1 : 0);
        if (chk_timing && w < NUM_REGS) check("word_cycle", cyc, 2 + 2 * w);
        if (w == start_word) start = 1'b1;
        if (w == bp_word) begin
          dump_if.out_ready = 1'b0;
          repeat (bp_len) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            check("hold_valid", dump_if.out_valid, 1);
            check("hold_data",  dump_if.out_data, exp_d);
            check("hold_addr",  dump_if.out_addr, exp_a);
          end
          dump_if.out_ready = 1'b1;
        end
        w++;
      end
      @(negedge clk);
      cyc++;
      start = 1'b0;
    end

    if (w < NWORDS) check("stream_timeout", w, NWORDS);
    check("end_done",  done, 1);
    check("end_busy",  busy, 0);
    check("end_state", dbg_state, S_DONE);
    check("end_valid", dump_if.out_valid, 0);
    if (chk_timing) check("done_cycle", cyc, DONE_CYC);
    @(negedge clk);
    check("post_done",  done, 0);
    check("post_state", dbg_state, S_IDLE);
    check("post_busy",  busy, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b0;
    start = 1'b0;
    dump_if.out_ready = 1'b1;
    preload();

    // Reset values
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);
    check("idle_state", dbg_state, S_IDLE);

    // Full dump, out_ready held high, cycle-exact timing
    build_exp(-1, '0);
    run_dump(-1, 0, -1, -1, -1, 1'b1);

    // Backpressure: out_ready low for 5 cycles on word 7
    build_exp(-1, '0);
    run_dump(7, 5, -1, -1, -1, 1'b0);

    // Start while busy at word 10 is ignored; timing unchanged
    build_exp(-1, '0);
    run_dump(-1, 0, 10, -1, -1, 1'b1);

    // Write to R5 during READ of R3: new value seen
    build_exp(5, 32'hDEAD_BEEF);
    run_dump(-1, 0, -1, 3, -1, 1'b1);
    preload();

    // Write to R5 during SEND of R5: old value kept
    build_exp(-1, '0);
    run_dump(-1, 0, -1, -1, 5, 1'b1);
    preload();

    // Asynchronous reset mid-stream, then a clean restart at address 0
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    #2 rst = 1'b0;
    #1 check_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_idle", dbg_state, S_IDLE);
    build_exp(-1, '0);
    run_dump(-1, 0, -1, -1, -1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
